// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-transfer flushes and
// multi-cycle MDU holds for the five-stage core, plus saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1_num,
  input  logic [4:0]       i_id_rs2_num,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [6:0]       i_ex_opcode,
  input  logic [4:0]       i_ex_rd_num,
  input  logic             i_ex_mdu_op,
  input  logic             i_ex_branch_taken,
  input  logic             i_mdu_done,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_mdu_start,
  output logic             o_mdu_err,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  localparam int TMO_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [6:0]       OP_LOAD  = 7'b0000011;

  typedef enum logic [0:0] {RUN, MDU_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mdu_err_q, mdu_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use;

  assign load_use = (i_ex_opcode == OP_LOAD) && (i_ex_rd_num != 5'd0) &&
                    ((i_id_uses_rs1 && (i_id_rs1_num == i_ex_rd_num)) ||
                     (i_id_uses_rs2 && (i_id_rs2_num == i_ex_rd_num)));

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    mdu_err_d     = mdu_err_q;
    stall_d       = stall_q;
    flush_d       = flush_q;
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b1;
    o_id_ex_flush = 1'b0;
    o_mdu_start   = 1'b0;

    if (!i_rst) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_en    = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      state_d       = RUN;
      tmo_d         = '0;
      mdu_err_d     = 1'b0;
      stall_d       = '0;
      flush_d       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (i_ex_branch_taken) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            if (flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
          end else if (i_ex_mdu_op) begin
            o_mdu_start = 1'b1;
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            state_d     = MDU_WAIT;
            tmo_d       = '0;
          end else if (load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          // Done wins over timeout so a late-but-valid result never raises the error.
          if (i_mdu_done || (tmo_q == TMO_LAST)) begin
            state_d = RUN;
            if (!i_mdu_done) mdu_err_d = 1'b1;
          end else begin
            o_pc_en    = 1'b0;
            o_if_id_en = 1'b0;
            o_id_ex_en = 1'b0;
            tmo_d      = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = RUN;
      endcase

      if (!o_pc_en && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      mdu_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mdu_err_q <= mdu_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign o_mdu_err      = mdu_err_q;
  assign o_stall_cycles = stall_q;
  assign o_flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MDU_TIMEOUT=8 and CNT_W=4 so the
// timeout and counter saturation are reachable in a short run.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_ALU    = 7'b0010011;
  // Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, mdu_start}
  localparam logic [15:0] CTL_RST   = 16'h000A;
  localparam logic [15:0] CTL_RUN   = 16'h0034;
  localparam logic [15:0] CTL_HOLD  = 16'h0000;
  localparam logic [15:0] CTL_START = 16'h0001;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_id_rs1_num, i_id_rs2_num, i_ex_rd_num;
  logic       i_id_uses_rs1, i_id_uses_rs2;
  logic [6:0] i_ex_opcode;
  logic       i_ex_mdu_op, i_ex_branch_taken, i_mdu_done;
  logic       o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic       o_mdu_start, o_mdu_err;
  logic [3:0] o_stall_cycles, o_flush_events;

  logic [15:0] ctl_w, stall_w, flush_w;
  int checks = 0;
  int errors = 0;

  assign ctl_w   = {10'd0, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush, o_mdu_start};
  assign stall_w = {12'd0, o_stall_cycles};
  assign flush_w = {12'd0, o_flush_events};

  always #5 i_clk = ~i_clk;

  pipe_hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1_num(i_id_rs1_num), .i_id_rs2_num(i_id_rs2_num),
    .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_ex_opcode(i_ex_opcode), .i_ex_rd_num(i_ex_rd_num),
    .i_ex_mdu_op(i_ex_mdu_op), .i_ex_branch_taken(i_ex_branch_taken),
    .i_mdu_done(i_mdu_done),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush),
    .o_mdu_start(o_mdu_start), .o_mdu_err(o_mdu_err),
    .o_stall_cycles(o_stall_cycles), .o_flush_events(o_flush_events)
  );

  // Drive one cycle's inputs just after the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic rst, input logic [6:0] opc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mdu,
                               input logic taken, input logic done);
    @(negedge i_clk);
    i_rst = rst; i_ex_opcode = opc; i_ex_rd_num = rd;
    i_id_rs1_num = rs1; i_id_rs2_num = rs2;
    i_id_uses_rs1 = u1; i_id_uses_rs2 = u2;
    i_ex_mdu_op = mdu; i_ex_branch_taken = taken; i_mdu_done = done;
    #1;
  endtask

  task automatic normalStep();
    applyStimulus(1'b1, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mduStep(input logic taken, input logic done);
    applyStimulus(1'b1, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, taken, done);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  initial begin
    i_rst = 1'b0; i_ex_opcode = OP_ALU; i_ex_rd_num = 5'd0;
    i_id_rs1_num = 5'd0; i_id_rs2_num = 5'd0; i_id_uses_rs1 = 1'b0; i_id_uses_rs2 = 1'b0;
    i_ex_mdu_op = 1'b0; i_ex_branch_taken = 1'b0; i_mdu_done = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_ctl", ctl_w, CTL_RST);
    end
    checkOutput("reset_stall", stall_w, 16'd0);
    checkOutput("reset_flush", flush_w, 16'd0);
    checkBit("reset_err", o_mdu_err, 1'b0);

    normalStep();
    checkOutput("run_after_reset", ctl_w, CTL_RUN);

    // Load-use on rs2
    applyStimulus(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkBit("lu_pc_en", o_pc_en, 1'b0);
    checkBit("lu_if_id_en", o_if_id_en, 1'b0);
    checkBit("lu_id_ex_flush", o_id_ex_flush, 1'b1);
    checkBit("lu_if_id_flush", o_if_id_flush, 1'b0);
    checkBit("lu_start", o_mdu_start, 1'b0);
    normalStep();
    checkOutput("lu_after_ctl", ctl_w, CTL_RUN);
    checkOutput("lu_stall_cnt", stall_w, 16'd1);

    applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rd0", ctl_w, CTL_RUN);
    applyStimulus(1'b1, OP_LOAD, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_unused", ctl_w, CTL_RUN);
    normalStep();
    checkOutput("lu_no_extra_stall", stall_w, 16'd1);

    // Taken transfer
    applyStimulus(1'b1, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkBit("br_pc_en", o_pc_en, 1'b1);
    checkBit("br_if_id_flush", o_if_id_flush, 1'b1);
    checkBit("br_id_ex_flush", o_id_ex_flush, 1'b1);
    checkBit("br_start", o_mdu_start, 1'b0);
    normalStep();
    checkOutput("br_after_ctl", ctl_w, CTL_RUN);
    checkOutput("br_flush_cnt", flush_w, 16'd1);
    checkOutput("br_stall_cnt", stall_w, 16'd1);

    // MDU: start, 4 waiting cycles (branch during wait ignored), done on the 5th
    mduStep(1'b0, 1'b0);
    checkOutput("mdu_start", ctl_w, CTL_START);
    for (int i = 1; i <= 4; i++) begin
      mduStep(i == 2, 1'b0);
      checkOutput("mdu_wait", ctl_w, CTL_HOLD);
    end
    mduStep(1'b0, 1'b1);
    checkOutput("mdu_release", ctl_w, CTL_RUN);
    checkOutput("mdu_stall_cnt", stall_w, 16'd6);
    normalStep();
    checkOutput("mdu_after_ctl", ctl_w, CTL_RUN);
    checkOutput("mdu_after_stall", stall_w, 16'd6);
    checkOutput("mdu_branch_ignored", flush_w, 16'd1);
    checkBit("mdu_no_err", o_mdu_err, 1'b0);

    // Timeout: 7 waiting cycles, forced release on the 8th
    mduStep(1'b0, 1'b0);
    checkOutput("tmo_start", ctl_w, CTL_START);
    for (int i = 0; i < 7; i++) begin
      mduStep(1'b0, 1'b0);
      checkOutput("tmo_wait", ctl_w, CTL_HOLD);
    end
    mduStep(1'b0, 1'b0);
    checkOutput("tmo_release", ctl_w, CTL_RUN);
    checkBit("tmo_err_not_yet", o_mdu_err, 1'b0);
    checkOutput("tmo_stall_cnt", stall_w, 16'd14);
    normalStep();
    checkOutput("tmo_after_ctl", ctl_w, CTL_RUN);
    checkBit("tmo_err_set", o_mdu_err, 1'b1);
    normalStep();
    checkBit("tmo_err_sticky", o_mdu_err, 1'b1);

    // Reset during MDU_WAIT; stall counter already at the saturation boundary
    mduStep(1'b0, 1'b0);
    checkOutput("mid_start", ctl_w, CTL_START);
    mduStep(1'b0, 1'b0);
    checkOutput("mid_wait1", ctl_w, CTL_HOLD);
    checkOutput("stall_at_max", stall_w, 16'd15);
    applyStimulus(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_reset_ctl", ctl_w, CTL_RST);
    checkOutput("stall_no_wrap", stall_w, 16'd15);
    normalStep();
    checkOutput("mid_back_to_run", ctl_w, CTL_RUN);
    checkBit("mid_err_clear", o_mdu_err, 1'b0);
    checkOutput("mid_stall_clear", stall_w, 16'd0);
    checkOutput("mid_flush_clear", flush_w, 16'd0);

    // 20 forced load-use stalls saturate a 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, OP_LOAD, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 15) checkOutput("sat_reach", stall_w, 16'd15);
    end
    normalStep();
    checkOutput("sat_hold", stall_w, 16'd15);
    checkOutput("sat_ctl", ctl_w, CTL_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
